// File: rtl/sisc_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : sisc_exec_unit
// Brief    : Five-cycle instruction sequencer with registered ALU and status
//            flags. Define SISC_SHIFT_EN to enable the SHL/SHR/SAR functions.
// Revision : 1.0 - initial release
// ============================================================================
module sisc_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] rsa,
    input  logic [DATA_W-1:0] rsb,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_result,
    output logic [3:0]        stat,
    output logic              stat_en,
    output logic              halt
);

    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        c_S_START     = 3'd0,
        c_S_FETCH     = 3'd1,
        c_S_DECODE    = 3'd2,
        c_S_EXECUTE   = 3'd3,
        c_S_MEM       = 3'd4,
        c_S_WRITEBACK = 3'd5,
        c_S_HALTED    = 3'd6
    } state_t;

    localparam logic [3:0] c_OP_ALU_R = 4'h1;
    localparam logic [3:0] c_OP_ALU_I = 4'h2;
    localparam logic [3:0] c_OP_MOV   = 4'h3;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    localparam logic [3:0] c_MM_ADD = 4'd0;
    localparam logic [3:0] c_MM_SUB = 4'd1;
    localparam logic [3:0] c_MM_AND = 4'd2;
    localparam logic [3:0] c_MM_OR  = 4'd3;
    localparam logic [3:0] c_MM_XOR = 4'd4;
    localparam logic [3:0] c_MM_NOT = 4'd5;
`ifdef SISC_SHIFT_EN
    localparam logic [3:0] c_MM_SHL = 4'd6;
    localparam logic [3:0] c_MM_SHR = 4'd7;
    localparam logic [3:0] c_MM_SAR = 4'd8;
    localparam logic [3:0] c_MM_MAX = 4'd8;
`else
    localparam logic [3:0] c_MM_MAX = 4'd5;
`endif

    state_t            r_state_q, w_state_d;
    logic              r_rf_we_q, w_rf_we_d;
    logic              r_wb_sel_q, w_wb_sel_d;
    logic [1:0]        r_alu_op_q, w_alu_op_d;
    logic [DATA_W-1:0] r_alu_result_q, w_alu_result_d;
    logic [3:0]        r_stat_q, w_stat_d;
    logic              r_stat_en_q, w_stat_en_d;
    logic              r_halt_q, w_halt_d;

    logic [3:0]        w_opcode;
    logic [3:0]        w_mm;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_is_alu;
    logic              w_is_mov;
    logic              w_mm_valid;
    logic              w_unused;

    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_dif;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_c;
    logic              w_alu_v;
    logic              w_alu_n;
    logic              w_alu_z;

    // Register specifiers are consumed by the register file, not here.
    assign w_unused   = ^ir[23:16];

    assign w_opcode   = ir[31:28];
    assign w_mm       = ir[27:24];
    assign w_imm_ext  = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign w_is_alu   = (w_opcode == c_OP_ALU_R) || (w_opcode == c_OP_ALU_I);
    assign w_is_mov   = (w_opcode == c_OP_MOV);
    assign w_mm_valid = (w_mm <= c_MM_MAX);

    always_comb begin
        w_op_b  = r_alu_op_q[0] ? w_imm_ext : rsb;
        w_sum   = {1'b0, rsa} + {1'b0, w_op_b};
        w_dif   = {1'b0, rsa} + {1'b0, ~w_op_b} + {{DATA_W{1'b0}}, 1'b1};
        w_alu_y = rsa;
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (w_mm)
            c_MM_ADD: begin
                w_alu_y = w_sum[DATA_W-1:0];
                w_alu_c = w_sum[DATA_W];
                w_alu_v = (rsa[DATA_W-1] == w_op_b[DATA_W-1]) &&
                          (w_alu_y[DATA_W-1] != rsa[DATA_W-1]);
            end
            c_MM_SUB: begin
                w_alu_y = w_dif[DATA_W-1:0];
                w_alu_c = w_dif[DATA_W];
                w_alu_v = (rsa[DATA_W-1] != w_op_b[DATA_W-1]) &&
                          (w_alu_y[DATA_W-1] != rsa[DATA_W-1]);
            end
            c_MM_AND: w_alu_y = rsa & w_op_b;
            c_MM_OR:  w_alu_y = rsa | w_op_b;
            c_MM_XOR: w_alu_y = rsa ^ w_op_b;
            c_MM_NOT: w_alu_y = ~rsa;
`ifdef SISC_SHIFT_EN
            c_MM_SHL: w_alu_y = rsa << w_op_b[SH_W-1:0];
            c_MM_SHR: w_alu_y = rsa >> w_op_b[SH_W-1:0];
            c_MM_SAR: w_alu_y = DATA_W'($signed(rsa) >>> w_op_b[SH_W-1:0]);
`endif
            default:  w_alu_y = rsa;
        endcase
        w_alu_n = w_alu_y[DATA_W-1];
        w_alu_z = (w_alu_y == '0);
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_S_START:     w_state_d = c_S_FETCH;
            c_S_FETCH:     w_state_d = c_S_DECODE;
            c_S_DECODE:    w_state_d = (w_opcode == c_OP_HALT) ? c_S_HALTED : c_S_EXECUTE;
            c_S_EXECUTE:   w_state_d = c_S_MEM;
            c_S_MEM:       w_state_d = c_S_WRITEBACK;
            c_S_WRITEBACK: w_state_d = c_S_FETCH;
            c_S_HALTED:    w_state_d = c_S_HALTED;
            default:       w_state_d = c_S_START;
        endcase

        // Control outputs are registered, so they are decoded from the state being entered.
        w_alu_op_d  = 2'b00;
        if ((w_state_d == c_S_EXECUTE) && w_is_alu) begin
            w_alu_op_d = {1'b1, (w_opcode == c_OP_ALU_I)};
        end
        w_stat_en_d = (w_state_d == c_S_EXECUTE) && w_is_alu && w_mm_valid;
        w_rf_we_d   = (w_state_d == c_S_WRITEBACK) && ((w_is_alu && w_mm_valid) || w_is_mov);
        w_wb_sel_d  = (w_state_d == c_S_WRITEBACK) && w_is_mov;
        w_halt_d    = (w_state_d == c_S_HALTED);

        w_alu_result_d = r_alu_op_q[1] ? w_alu_y : r_alu_result_q;
        w_stat_d       = r_stat_en_q ? {w_alu_c, w_alu_v, w_alu_n, w_alu_z} : r_stat_q;
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state_q      <= c_S_START;
            r_rf_we_q      <= 1'b0;
            r_wb_sel_q     <= 1'b0;
            r_alu_op_q     <= 2'b00;
            r_alu_result_q <= '0;
            r_stat_q       <= 4'b0000;
            r_stat_en_q    <= 1'b0;
            r_halt_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_rf_we_q      <= w_rf_we_d;
            r_wb_sel_q     <= w_wb_sel_d;
            r_alu_op_q     <= w_alu_op_d;
            r_alu_result_q <= w_alu_result_d;
            r_stat_q       <= w_stat_d;
            r_stat_en_q    <= w_stat_en_d;
            r_halt_q       <= w_halt_d;
        end
    end

    assign rf_we      = r_rf_we_q;
    assign wb_sel     = r_wb_sel_q;
    assign alu_op     = r_alu_op_q;
    assign alu_result = r_alu_result_q;
    assign stat       = r_stat_q;
    assign stat_en    = r_stat_en_q;
    assign halt       = r_halt_q;
    assign wb_data    = r_wb_sel_q ? rsa : r_alu_result_q;

endmodule
`default_nettype wire

// File: tb/tb_sisc_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sisc_exec_unit
// Brief    : Directed and randomized self-checking bench for sisc_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sisc_exec_unit;

`ifdef SISC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] ir;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic        rf_we;
    logic        wb_sel;
    logic [31:0] wb_data;
    logic [1:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic        stat_en;
    logic        halt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_res  = 32'h0;
    logic [3:0]  m_stat = 4'h0;

    sisc_exec_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .ir         (ir),
        .rsa        (rsa),
        .rsb        (rsb),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .wb_data    (wb_data),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .stat       (stat),
        .stat_en    (stat_en),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions: wide sums for carry,
    // signed wide sums compared with the wrapped result for overflow.
    function automatic void ref_alu(input logic [3:0] mm, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] y,
                                    output logic [3:0] f, output bit valid);
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          s  = 0;
        bit              c  = 1'b0;
        bit              v  = 1'b0;
        valid = 1'b1;
        y     = a;
        case (mm)
            4'd0: begin
                y = 32'(ua + ub);
                c = (ua + ub) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s != longint'($signed(y)));
            end
            4'd1: begin
                y = 32'(ua - ub);
                c = (ua >= ub);
                s = sa - sb;
                v = (s != longint'($signed(y)));
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = ~a;
            4'd6: if (SHIFT_EN) y = a << b[4:0]; else valid = 1'b0;
            4'd7: if (SHIFT_EN) y = a >> b[4:0]; else valid = 1'b0;
            4'd8: if (SHIFT_EN) y = 32'($signed(a) >>> b[4:0]); else valid = 1'b0;
            default: valid = 1'b0;
        endcase
        if (!valid) y = a;
        f = {c, v, y[31], (y == 32'h0)};
    endfunction

    // Drives one instruction from the negedge before FETCH and checks the
    // outputs in each of its five cycles.
    task automatic run_instr(input string name, input logic [31:0] i_ir,
                             input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  op;
        logic [31:0] opb;
        logic [31:0] y;
        logic [3:0]  f;
        bit          valid;
        bit          is_alu;
        bit          is_mov;
        bit          does_wr;
        op  = i_ir[31:28];
        opb = (op == 4'h2) ? {{16{i_ir[15]}}, i_ir[15:0]} : b;
        ref_alu(i_ir[27:24], a, opb, y, f, valid);
        is_alu  = (op == 4'h1) || (op == 4'h2);
        is_mov  = (op == 4'h3);
        does_wr = (is_alu && valid) || is_mov;
        ir  = i_ir;
        rsa = a;
        rsb = b;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 3 && is_alu) begin
                m_res = y;
                if (valid) m_stat = f;
            end
            chk($sformatf("%s.c%0d.alu_op", name, k), alu_op,
                (k == 2 && is_alu) ? {1'b1, op == 4'h2} : 2'b00);
            chk($sformatf("%s.c%0d.stat_en", name, k), stat_en, k == 2 && is_alu && valid);
            chk($sformatf("%s.c%0d.rf_we", name, k), rf_we, k == 4 && does_wr);
            chk($sformatf("%s.c%0d.wb_sel", name, k), wb_sel, k == 4 && is_mov);
            chk($sformatf("%s.c%0d.alu_result", name, k), alu_result, m_res);
            chk($sformatf("%s.c%0d.stat", name, k), stat, m_stat);
            chk($sformatf("%s.c%0d.wb_data", name, k), wb_data, (k == 4 && is_mov) ? a : m_res);
            chk($sformatf("%s.c%0d.halt", name, k), halt, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".rf_we"}, rf_we, 1'b0);
        chk({name, ".wb_sel"}, wb_sel, 1'b0);
        chk({name, ".alu_op"}, alu_op, 2'b00);
        chk({name, ".alu_result"}, alu_result, 32'h0);
        chk({name, ".stat"}, stat, 4'h0);
        chk({name, ".stat_en"}, stat_en, 1'b0);
        chk({name, ".halt"}, halt, 1'b0);
        chk({name, ".wb_data"}, wb_data, 32'h0);
    endtask

    initial begin
        logic [3:0]  ops [5];
        logic [31:0] specials [4];
        logic [31:0] r_ir, ra, rb;
        ops      = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7};
        specials = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};

        rst_f = 1'b1;
        ir    = 32'h0;
        rsa   = 32'h0;
        rsb   = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_f = 1'b0;

        run_instr("add", 32'h1012_3000, 32'd5, 32'd3);
        chk("add.result", alu_result, 32'd8);
        chk("add.stat", stat, 4'b0000);
        chk("add.wb_data", wb_data, 32'd8);

        run_instr("sub", 32'h1112_3000, 32'd7, 32'd7);
        chk("sub.result", alu_result, 32'd0);
        chk("sub.stat", stat, 4'b1001);

        run_instr("addov", 32'h1012_3000, 32'h7FFF_FFFF, 32'd1);
        chk("addov.result", alu_result, 32'h8000_0000);
        chk("addov.stat", stat, 4'b0110);

        run_instr("addi", 32'h2012_FFFF, 32'd10, 32'd0);
        chk("addi.result", alu_result, 32'd9);
        chk("addi.stat", stat, 4'b1000);

        run_instr("mov", 32'h3010_0000, 32'hDEAD_BEEF, 32'h1234_5678);
        run_instr("nop", 32'h0000_0000, 32'h1111_1111, 32'h2222_2222);
        run_instr("badmm", 32'h1F12_3000, 32'hCAFE_0001, 32'h5);
        run_instr("shl", 32'h1612_3000, 32'h8000_0003, 32'd4);

        for (int n = 0; n < 40; n++) begin
            r_ir = {ops[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom)};
            ra   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            run_instr($sformatf("rnd%0d", n), r_ir, ra, rb);
        end

        // Reset while an ALU instruction is in EXECUTE.
        run_instr("pre", 32'h1312_0000, 32'hF0F0_0000, 32'h0000_0F0F);
        ir  = 32'h1012_3000;
        rsa = 32'd100;
        rsb = 32'd23;
        repeat (3) @(negedge clk);
        chk("mid.alu_op", alu_op, 2'b10);
        rst_f = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst_f  = 1'b0;
        m_res  = 32'h0;
        m_stat = 4'h0;
        run_instr("post_mid", 32'h1012_3000, 32'd100, 32'd23);

        ir = 32'hF000_0000;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("halt.c%0d.halt", k), halt, k >= 2);
            chk($sformatf("halt.c%0d.rf_we", k), rf_we, 1'b0);
            chk($sformatf("halt.c%0d.alu_op", k), alu_op, 2'b00);
            chk($sformatf("halt.c%0d.stat_en", k), stat_en, 1'b0);
        end
        rst_f = 1'b1;
        @(negedge clk);
        chk_all_zero("halt_reset");
        rst_f  = 1'b0;
        m_res  = 32'h0;
        m_stat = 4'h0;
        run_instr("resume", 32'h1012_3000, 32'd5, 32'd3);
        chk("resume.result", alu_result, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
